// File: rtl/p2s_rr_arbiter_if.sv
// Handshake bundle between M parallel requesters, the round-robin arbiter and
// the parallel side of the shared serializer.
interface p2s_rr_arbiter_if #(
  parameter int N = 8,
  parameter int M = 4
) ();
  localparam int GW = $clog2(M);

  logic [M-1:0]   req_valid;
  logic [M*N-1:0] req_data;
  logic [M-1:0]   req_ready;
  logic           p_valid;
  logic [N-1:0]   p_data;
  logic           p_ready;
  logic [GW-1:0]  grant_id;
  logic           busy;

  // slave: the arbiter itself; master: requesters plus serializer around it
  modport slave (
    input  req_valid, req_data, p_ready,
    output req_ready, p_valid, p_data, grant_id, busy
  );

  modport master (
    output req_valid, req_data, p_ready,
    input  req_ready, p_valid, p_data, grant_id, busy
  );
endinterface

// File: rtl/p2s_rr_arbiter.sv
// Round-robin arbiter sharing one parallel-to-serial serializer between M
// requesters; grants bursts of up to BURST words with one idle arbitration cycle.
module p2s_rr_arbiter #(
  parameter int N     = 8,
  parameter int M     = 4,
  parameter int BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  p2s_rr_arbiter_if.slave bus
);
  localparam int GW = $clog2(M);
  localparam int CW = $clog2(BURST + 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  localparam logic [GW-1:0] LAST_ID  = GW'(M - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BURST - 1);
  localparam logic [M-1:0]  ONE_HOT0 = {{(M-1){1'b0}}, 1'b1};

  logic [0:0]     state_q, state_d;
  logic [GW-1:0]  grant_q, grant_d;
  logic [GW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  logic [M-1:0]   valid_sh;
  logic [M*N-1:0] data_sh;
  logic           in_grant;
  logic           g_valid;
  logic           xfer;
  logic           release_c;
  logic [GW:0]    pick;

  // Returns {found, index}: first set bit of v searching p, p+1, ... mod M.
  function automatic logic [GW:0] rr_pick(input logic [M-1:0] v, input logic [GW-1:0] p);
    logic [GW:0]  r;
    logic [M-1:0] vs;
    int           idx;
    r = '0;
    for (int k = M - 1; k >= 0; k--) begin
      idx = (int'(p) + k) % M;
      vs  = v >> idx;
      if (vs[0]) r = {1'b1, GW'(idx)};
    end
    return r;
  endfunction

  assign in_grant = (state_q == S_GRANT);
  assign valid_sh = bus.req_valid >> grant_q;
  assign data_sh  = bus.req_data >> (int'(grant_q) * N);
  assign g_valid  = in_grant && valid_sh[0];
  assign xfer     = g_valid && bus.p_ready;

  // Granted requester is wired straight through to the serializer
  assign bus.p_valid   = g_valid;
  assign bus.p_data    = in_grant ? data_sh[N-1:0] : '0;
  assign bus.req_ready = (in_grant && bus.p_ready) ? (ONE_HOT0 << grant_q) : '0;
  assign bus.grant_id  = grant_q;
  assign bus.busy      = in_grant;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    release_c = 1'b0;
    pick      = rr_pick(bus.req_valid, ptr_q);

    if (state_q == S_IDLE) begin
      if (pick[GW]) begin
        grant_d = pick[GW-1:0];
        cnt_d   = '0;
        state_d = S_GRANT;
      end
    end else begin
      if (xfer) begin
        cnt_d     = cnt_q + 1'b1;
        release_c = (cnt_q == LAST_CNT);
      end else if (!valid_sh[0]) begin
        // requester withdrew: give the slot away instead of waiting
        release_c = 1'b1;
      end

      if (release_c) begin
        state_d = S_IDLE;
        ptr_d   = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
